// File: rtl/s2mm_stream_packer.sv
// s2mm_stream_packer
//   Packs a narrow AXI-Stream of IN_W-bit samples into RATIO-lane wide beats
//   for the DMA S2MM data input. A word closes when its last lane fills or an
//   input tlast arrives; short words are zero-padded with tkeep cleared on the
//   empty lanes. Output tlast marks the end of a frame, either from the input
//   tlast or from a programmable beat count.
//
// Ports
//   clk, resetn       rising-edge clock, synchronous active-low reset
//   cfg_frame_beats   output beats per frame (0: only s_tlast ends a frame),
//                     captured on the first sample of each frame
//   s_t*              narrow input stream (valid/ready/data/last)
//   m_t*              wide output stream (valid/ready/data/keep/last)
//   stat_frames       count of frames emitted, wrapping
//   stat_short        one-cycle pulse when s_tlast ends a frame before the
//                     configured length
module s2mm_stream_packer #(
   parameter int IN_W  = 32,
   parameter int RATIO = 4,
   parameter int CNT_W = 16
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [CNT_W-1:0]          cfg_frame_beats,
   input  logic                      s_tvalid,
   output logic                      s_tready,
   input  logic [IN_W-1:0]           s_tdata,
   input  logic                      s_tlast,
   output logic                      m_tvalid,
   input  logic                      m_tready,
   output logic [IN_W*RATIO-1:0]     m_tdata,
   output logic [IN_W*RATIO/8-1:0]   m_tkeep,
   output logic                      m_tlast,
   output logic [CNT_W-1:0]          stat_frames,
   output logic                      stat_short
);

   localparam int OUT_W      = IN_W * RATIO;
   localparam int KEEP_W     = OUT_W / 8;
   localparam int LANE_BYTES = IN_W / 8;
   localparam int LANE_W     = (RATIO > 1) ? $clog2(RATIO) : 1;

   typedef enum logic {
      IDLE,
      FILL
   } frame_state_t;

   frame_state_t state, state_next;

   logic [IN_W-1:0]   lane_data [RATIO];
   logic [LANE_W-1:0] lane;
   logic [RATIO-1:0]  mask;
   logic [CNT_W-1:0]  beat;
   logic [CNT_W-1:0]  cfg_q;

   logic              accept;
   logic              first;
   logic              last_lane;
   logic              complete;
   logic [CNT_W-1:0]  cfg_eff;
   logic [CNT_W:0]    beat_inc;
   logic              len_hit;
   logic              short_hit;
   logic              word_last;
   logic [CNT_W-1:0]  beat_after;
   logic [OUT_W-1:0]  word_data;
   logic [KEEP_W-1:0] word_keep;

   assign s_tready = resetn && (!m_tvalid || m_tready);
   assign accept   = s_tvalid && s_tready;

   // IDLE coincides exactly with beat == 0 && lane == 0 (see state_next),
   // so it marks the first sample of a frame.
   assign first     = (state == IDLE);
   // The first sample of a frame already obeys the length it latches.
   assign cfg_eff   = first ? cfg_frame_beats : cfg_q;
   assign last_lane = (lane == LANE_W'(RATIO - 1));
   assign complete  = accept && (last_lane || s_tlast);

   // Beat arithmetic is one bit wider so beat+1 never aliases to 0.
   assign beat_inc   = {1'b0, beat} + (CNT_W + 1)'(1);
   assign len_hit    = (cfg_eff != '0) && (beat_inc == {1'b0, cfg_eff});
   assign short_hit  = s_tlast && (cfg_eff != '0) && (beat_inc < {1'b0, cfg_eff});
   assign word_last  = s_tlast || len_hit;
   assign beat_after = word_last ? '0 : beat_inc[CNT_W-1:0];

   // Assemble the completing word: stored lanes, the incoming sample in the
   // current lane, and zeros with cleared keep above it.
   always_comb begin
      word_data = '0;
      word_keep = '0;
      for (int unsigned k = 0; k < RATIO; k++) begin
         if (lane == LANE_W'(k)) begin
            word_data[k*IN_W +: IN_W]             = s_tdata;
            word_keep[k*LANE_BYTES +: LANE_BYTES] = '1;
         end else if (mask[k]) begin
            word_data[k*IN_W +: IN_W]             = lane_data[k];
            word_keep[k*LANE_BYTES +: LANE_BYTES] = '1;
         end
      end
   end

   // Frame FSM: back to IDLE whenever an accept leaves lane and beat at 0.
   always_comb begin
      state_next = state;
      if (accept) begin
         if (complete && (beat_after == '0))
            state_next = IDLE;
         else
            state_next = FILL;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Lane storage needs no reset: the mask gates every read.
   always_ff @(posedge clk) begin
      if (accept)
         lane_data[lane] <= s_tdata;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         lane  <= '0;
         mask  <= '0;
         beat  <= '0;
         cfg_q <= '0;
      end else if (accept) begin
         if (first)
            cfg_q <= cfg_frame_beats;
         if (complete) begin
            lane <= '0;
            mask <= '0;
            beat <= beat_after;
         end else begin
            lane       <= lane + LANE_W'(1);
            mask[lane] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         m_tvalid    <= 1'b0;
         m_tdata     <= '0;
         m_tkeep     <= '0;
         m_tlast     <= 1'b0;
         stat_frames <= '0;
         stat_short  <= 1'b0;
      end else begin
         stat_short <= complete && short_hit;
         if (complete) begin
            m_tvalid <= 1'b1;
            m_tdata  <= word_data;
            m_tkeep  <= word_keep;
            m_tlast  <= word_last;
            if (word_last)
               stat_frames <= stat_frames + CNT_W'(1);
         end else if (m_tready) begin
            m_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_s2mm_stream_packer.sv
// tb_s2mm_stream_packer
//   Directed scenarios followed by a randomized run of the packer. Expected
//   beats come from a list-based model: samples are collected into a word,
//   each finished word is emitted as one beat, and frame boundaries follow
//   the beat count latched at the start of each frame.
module tb_s2mm_stream_packer;

   localparam int IN_W  = 32;
   localparam int RATIO = 4;
   localparam int CNT_W = 16;
   localparam int OUT_W = IN_W * RATIO;
   localparam int KB    = IN_W / 8;

   logic                 clk = 1'b0;
   logic                 resetn = 1'b0;
   logic [CNT_W-1:0]     cfg = '0;
   logic                 s_tvalid = 1'b0;
   logic                 s_tready;
   logic [IN_W-1:0]      s_tdata = '0;
   logic                 s_tlast = 1'b0;
   logic                 m_tvalid;
   logic                 m_tready = 1'b0;
   logic [OUT_W-1:0]     m_tdata;
   logic [OUT_W/8-1:0]   m_tkeep;
   logic                 m_tlast;
   logic [CNT_W-1:0]     stat_frames;
   logic                 stat_short;

   s2mm_stream_packer #(.IN_W(IN_W), .RATIO(RATIO), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .cfg_frame_beats (cfg),
      .s_tvalid        (s_tvalid),
      .s_tready        (s_tready),
      .s_tdata         (s_tdata),
      .s_tlast         (s_tlast),
      .m_tvalid        (m_tvalid),
      .m_tready        (m_tready),
      .m_tdata         (m_tdata),
      .m_tkeep         (m_tkeep),
      .m_tlast         (m_tlast),
      .stat_frames     (stat_frames),
      .stat_short      (stat_short)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [OUT_W-1:0]   d;
      logic [OUT_W/8-1:0] k;
      logic               l;
   } beat_t;

   beat_t got[$];
   beat_t exp_q[$];
   int unsigned short_cnt = 0;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // model state
   logic [IN_W-1:0] mw[$];
   int unsigned     m_fb = 0;
   logic [CNT_W-1:0] m_fcfg = '0;
   int unsigned     m_frames = 0;
   int unsigned     m_shorts = 0;

   bit ready_mode = 1'b0;

   // Output monitor, sampled mid-cycle.
   initial forever begin
      @(negedge clk);
      if (resetn === 1'b1) begin
         if (m_tvalid === 1'b1 && m_tready === 1'b1)
            got.push_back('{m_tdata, m_tkeep, m_tlast});
         if (stat_short === 1'b1)
            short_cnt++;
      end
   end

   // Random backpressure while enabled.
   initial forever begin
      @(posedge clk);
      #1;
      if (ready_mode)
         m_tready = (($urandom % 4) != 0);
   end

   task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      mw.delete();
      m_fb     = 0;
      m_frames = 0;
   endtask

   task automatic model_push(input logic [IN_W-1:0] d, input logic l);
      beat_t b;
      if (mw.size() == 0 && m_fb == 0)
         m_fcfg = cfg;
      mw.push_back(d);
      if (mw.size() == RATIO || l) begin
         b.d = '0;
         b.k = '0;
         for (int k = 0; k < mw.size(); k++) begin
            b.d[k*IN_W +: IN_W] = mw[k];
            b.k[k*KB +: KB]     = '1;
         end
         b.l = l || (m_fcfg != 0 && m_fb + 1 == m_fcfg);
         if (l && m_fcfg != 0 && m_fb + 1 < m_fcfg)
            m_shorts++;
         if (b.l) begin
            m_frames++;
            m_fb = 0;
         end else begin
            m_fb++;
         end
         exp_q.push_back(b);
         mw.delete();
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the sample is taken.
   task automatic send(input logic [IN_W-1:0] d, input logic l);
      int unsigned n = 0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = l;
      @(negedge clk);
      while (s_tready !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("accept_timeout", s_tready, 1);
      model_push(d, l);
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic compare_all(input string tag);
      int unsigned n = 0;
      while (got.size() < exp_q.size() && n < 3000) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      check({tag, "_beats"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         check($sformatf("%s_data%0d", tag, i), got[i].d, exp_q[i].d);
         check($sformatf("%s_keep%0d", tag, i), got[i].k, exp_q[i].k);
         check($sformatf("%s_last%0d", tag, i), got[i].l, exp_q[i].l);
      end
      check({tag, "_frames"}, stat_frames, CNT_W'(m_frames));
      check({tag, "_shorts"}, short_cnt, m_shorts);
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      got.delete();
      exp_q.delete();
   endtask

   initial begin
      int unsigned sh0;
      logic [OUT_W-1:0] held;
      logic [IN_W-1:0]  rd;

      // Reset state
      idle(3);
      check("rst_tvalid", m_tvalid, 0);
      check("rst_tdata",  m_tdata,  0);
      check("rst_tkeep",  m_tkeep,  0);
      check("rst_tlast",  m_tlast,  0);
      check("rst_frames", stat_frames, 0);
      check("rst_short",  stat_short, 0);
      check("rst_tready", s_tready, 0);
      resetn = 1'b1;
      idle(1);

      // Length-terminated frame of full beats
      cfg = 16'd4;
      m_tready = 1'b1;
      for (int i = 1; i <= 16; i++) send(IN_W'(i), 1'b0);
      compare_all("t1");
      check("t1_beat0", got[0].d, 128'h00000004_00000003_00000002_00000001);
      check("t1_frames_abs", stat_frames, 1);
      check("t1_noshort", short_cnt, 0);
      flush();

      // Early s_tlast with a short final word
      for (int i = 1; i <= 6; i++) send(IN_W'(i), i == 6);
      compare_all("t2");
      check("t2_last_data", got[1].d, 128'h00000006_00000005);
      check("t2_last_keep", got[1].k, 16'h00FF);
      check("t2_last_flag", got[1].l, 1);
      check("t2_short", short_cnt, 1);
      flush();

      // Output backpressure holds data and stalls input
      m_tready = 1'b0;
      for (int i = 1; i <= 4; i++) send(IN_W'(32'h100 + i), 1'b0);
      held = exp_q[0].d;
      s_tvalid = 1'b1;
      s_tdata  = 32'h105;
      s_tlast  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t3_hold_valid", m_tvalid, 1);
         check("t3_hold_data", m_tdata, held);
         check("t3_stall", s_tready, 0);
      end
      @(posedge clk);
      #1;
      m_tready = 1'b1;
      for (int i = 5; i <= 16; i++) send(IN_W'(32'h100 + i), 1'b0);
      compare_all("t3");
      flush();

      // Length tlast disabled
      cfg = 16'd0;
      sh0 = short_cnt;
      for (int i = 1; i <= 9; i++) send(IN_W'(32'h200 + i), i == 9);
      compare_all("t4");
      check("t4_last_keep", got[2].k, 16'h000F);
      check("t4_last_flag", got[2].l, 1);
      check("t4_noshort", short_cnt, sh0);
      flush();

      // Length change mid-frame takes effect on the next frame
      cfg = 16'd4;
      for (int i = 1; i <= 24; i++) begin
         if (i == 6) cfg = 16'd2;
         send(IN_W'(32'h300 + i), 1'b0);
      end
      compare_all("t5");
      check("t5_end_frame1", got[3].l, 1);
      check("t5_mid_frame2", got[4].l, 0);
      check("t5_end_frame2", got[5].l, 1);
      flush();

      // Reset mid-word
      cfg = 16'd4;
      send(32'hEE01, 1'b0);
      send(32'hEE02, 1'b0);
      resetn = 1'b0;
      idle(1);
      check("t6_tvalid", m_tvalid, 0);
      check("t6_tdata",  m_tdata,  0);
      check("t6_tkeep",  m_tkeep,  0);
      check("t6_tlast",  m_tlast,  0);
      check("t6_frames", stat_frames, 0);
      check("t6_tready", s_tready, 0);
      resetn = 1'b1;
      model_reset();
      flush();
      for (int i = 0; i < 4; i++) send(IN_W'(32'hA + i), 1'b0);
      compare_all("t6");
      check("t6_beat", got[0].d, 128'h0000000D_0000000C_0000000B_0000000A);
      check("t6_frames_after", stat_frames, 0);
      flush();

      // Randomized traffic with backpressure and length changes
      ready_mode = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (($urandom % 25) == 0) begin
            case ($urandom % 5)
               0: cfg = 16'd0;
               1: cfg = 16'd1;
               2: cfg = 16'd2;
               3: cfg = 16'd3;
               default: cfg = 16'd5;
            endcase
         end
         if (($urandom % 3) == 0) idle($urandom % 3);
         rd = $urandom;
         send(rd, ($urandom % 8) == 0);
      end
      send(32'hFEED, 1'b1);
      ready_mode = 1'b0;
      m_tready = 1'b1;
      compare_all("rnd");
      flush();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/s2mm_stream_packer.md
# s2mm_stream_packer

Stream-side feeder for the DMA S2MM channel. It accepts a narrow AXI-Stream of samples, packs RATIO samples into one wide beat, and asserts tlast at a configurable frame length or early on an input tlast. Short final words are flushed with a matching tkeep. The block sits directly upstream of the DMA `dat1_i_*` stream input and drives it with DDR-width beats.

## Interface
Parameters:
- IN_W, 32, input sample width in bits (multiple of 8)
- RATIO, 4, samples per output beat; OUT_W = IN_W*RATIO (128 by default, the DDR width)
- CNT_W, 16, width of the frame-length config and the statistics counters

Ports:
- clk  in  1  system clock; every register is on the rising edge
- resetn  in  1  reset, synchronous and active-low
- cfg_frame_beats  in  CNT_W  output beats per frame; 0 = length tlast disabled (only s_tlast ends a frame)
- s_tvalid  in  1  input sample valid
- s_tready  out  1  input ready
- s_tdata  in  IN_W  input sample
- s_tlast  in  1  ends the frame after this sample
- m_tvalid  out  1  output beat valid (to DMA dat1_i_tvalid)
- m_tready  in  1  DMA ready
- m_tdata  out  OUT_W  packed beat; lane k in bits [k*IN_W +: IN_W]
- m_tkeep  out  OUT_W/8  byte enables
- m_tlast  out  1  last beat of frame
- stat_frames  out  CNT_W  frames emitted, wraps
- stat_short  out  1  one-cycle pulse: frame ended by s_tlast before cfg_frame_beats

## Operation
- Accumulator: RATIO lane registers, lane index `lane` (0..RATIO-1), and a lane-valid mask.
- Output register: m_tdata/m_tkeep/m_tlast/m_tvalid, loaded only when a word completes.
- s_tready = resetn && (!m_tvalid || m_tready). The input stalls whenever the output holds an unaccepted beat, even if the current sample would not complete a word.
- Accept (s_tvalid && s_tready):
  - Write s_tdata into lane `lane` and set its mask bit.
  - The word completes if lane == RATIO-1 or s_tlast.
- On completion:
  - Load the output register in the same edge. Filled lanes carry data; unfilled lanes are 0 with tkeep 0.
  - Lane keep = IN_W/8 ones per filled lane.
  - Clear lane and mask.
- Beat counter `beat` (CNT_W) increments on each completed word.
- tlast:
  - Set m_tlast when s_tlast is accepted, or when cfg_frame_beats != 0 and beat+1 == cfg_frame_beats.
  - When tlast is set: beat <= 0 and stat_frames increments, both at load time.
- stat_short pulses at load when tlast came from s_tlast and cfg_frame_beats != 0 and beat+1 < cfg_frame_beats.
- If s_tlast coincides with the length-based last beat, emit a single tlast and no stat_short.
- cfg_frame_beats is latched into cfg_q on the first accepted sample of each frame (beat==0 && lane==0). Mid-frame changes are ignored.
- State machine (frame): IDLE (beat==0, lane==0) -> FILL on the first accept -> IDLE after the tlast word loads.
- Wrap-around:
  - The beat counter never exceeds cfg_q-1 when cfg_q != 0.
  - When cfg_q == 0, beat wraps modulo 2^CNT_W.

## Timing
- Reset (resetn low at a clk edge) forces: m_tvalid 0, m_tdata 0, m_tkeep 0, m_tlast 0, stat_frames 0, stat_short 0, lane 0, mask 0, beat 0, cfg_q 0. s_tready is 0 while resetn is low.
- Reset mid-frame discards the partial word and the held output beat. No tlast is generated.
- Latency: m_tvalid rises on the edge that accepts the completing sample, i.e. visible the cycle after that sample is presented.
- Throughput: 1 sample/cycle sustained while m_tready=1; one output beat per RATIO cycles.
- Output handshake:
  - m_tdata/m_tkeep/m_tlast stay stable while m_tvalid && !m_tready.
  - m_tvalid falls on the edge where m_tready is seen, unless a new word loads on that same edge.
  - A simultaneous drain and load keeps m_tvalid high with the new word.
- stat_short is high for exactly one cycle, aligned with the load edge.

## Test plan
- cfg=4, 16 samples 0x1..0x10 with m_tready=1 -> 4 beats; beat0 = 0x00000004_00000003_00000002_00000001; m_tkeep 0xFFFF on all; m_tlast on beat 3 only; stat_frames=1; no stat_short.
- cfg=4, 6 samples, s_tlast on the 6th -> 2 beats; beat1 lanes 0-1 = 0x5, 0x6, upper lanes 0; m_tkeep 0x00FF; m_tlast=1; stat_short pulse; stat_frames=1.
- m_tready held 0 for 10 cycles after the first beat -> m_tdata stable; s_tready 0 throughout; no sample lost; the sequence resumes intact when m_tready returns to 1.
- cfg=0, 9 samples with s_tlast on the 9th -> 3 beats; the last has keep 0x000F and m_tlast=1; no stat_short.
- cfg changed from 4 to 2 mid-frame -> the current frame still ends on beat 3; the next frame ends after 2 beats.
- resetn pulsed low for 1 cycle after 2 samples of a word -> all outputs 0; the next 4 samples form a full beat starting at lane 0; stat_frames=0.
